// File: rtl/timera_iv_ctrl_pkg.sv
// rtl/timera_iv_ctrl_pkg.sv - shared addresses, IV codes and FSM states for the Timer_A IV controller
package timera_iv_ctrl_pkg;

   // Word-aligned byte addresses of the TAxIV registers
   localparam logic [15:0] TA0IV = 16'h012E;
   localparam logic [15:0] TA1IV = 16'h011E;

   // Interrupt vector codes
   localparam logic [7:0] TAIV_NONE  = 8'h00;
   localparam logic [7:0] TAIV_TAIFG = 8'h0E;

   // CCRi vector code is simply twice the unit index
   function automatic logic [7:0] taiv_ccr(input int idx);
      return 8'(2 * idx);
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_HOLD = 2'd2
   } iv_state_e;

endpackage

// File: rtl/timera_iv_ctrl_prio.sv
// rtl/timera_iv_ctrl_prio.sv - priority encoder from pending flags to IV code and one-hot clear vector
module timera_iv_ctrl_prio
   import timera_iv_ctrl_pkg::*;
#(
   parameter int NCCR = 3
) (
   input  logic [NCCR-1:0] pend_i,    // bit 0 (CCR0) has its own vector and is ignored here
   input  logic            pend_t_i,  // timer overflow pending
   output logic [7:0]      code_o,
   output logic [NCCR:0]   clr_o      // bit NCCR selects TAIFG, bits 1..NCCR-1 select CCRi
);

   logic unused_ccr0;
   assign unused_ccr0 = pend_i[0];

   // Lowest-numbered pending CC unit wins; TAIFG only when no CC unit is pending
   always_comb begin
      code_o = TAIV_NONE;
      clr_o  = '0;
      if (pend_t_i) begin
         code_o      = TAIV_TAIFG;
         clr_o[NCCR] = 1'b1;
      end
      for (int i = NCCR - 1; i >= 1; i--) begin
         if (pend_i[i]) begin
            code_o   = taiv_ccr(i);
            clr_o    = '0;
            clr_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timera_iv_ctrl.sv
// rtl/timera_iv_ctrl.sv - Timer_A interrupt vector controller top; TIMERA_IV_WRITECLR_EN makes TAxIV writes clear flags
module timera_iv_ctrl
   import timera_iv_ctrl_pkg::*;
#(
   parameter logic [15:0] TAnIV = TA0IV,
   parameter int          NCCR  = 3
) (
   input  logic            MCLK,
   input  logic            reset_n,
   input  logic [15:0]     MAB,
   input  logic [15:0]     MDBwrite,
   input  logic            MR,
   input  logic            MW,
   input  logic            BW,
   input  logic            TAIFG,
   input  logic            TAIE,
   input  logic [NCCR-1:0] CCIFG,
   input  logic [NCCR-1:0] CCIE,
   input  logic            INTACK0,
   output logic [15:0]     MDBread,
   output logic            IRQ0,
   output logic            IRQ1,
   output logic [NCCR-1:0] CCIFGclr,
   output logic            TAIFGclr
);

   logic [NCCR-1:0] pend;
   logic            pend_t;
   logic [7:0]      iv_d, iv_q;
   logic [NCCR:0]   clrv_d, clrv_q;
   logic [NCCR:0]   tgt_d, tgt_q;
   logic            irq0_q, irq1_q, intack_q;
   iv_state_e       state_d, state_q;
   logic            addr_hit, acc, rd_sel, clr_fire;
   logic            unused_bus;

   // Write data only marks an access; its value never matters
   assign unused_bus = ^{MDBwrite, MW};

   assign pend   = CCIFG & CCIE;
   assign pend_t = TAIFG & TAIE;

   timera_iv_ctrl_prio #(.NCCR(NCCR)) u_prio (
      .pend_i   (pend),
      .pend_t_i (pend_t),
      .code_o   (iv_d),
      .clr_o    (clrv_d)
   );

   assign addr_hit = (MAB[15:1] == TAnIV[15:1]);
`ifdef TIMERA_IV_WRITECLR_EN
   assign acc = (MR | MW) & addr_hit;
`else
   assign acc = MR & addr_hit;
`endif
   assign rd_sel = MR & addr_hit;

   // Upper byte of a byte read reads as zero; bus is released when not addressed
   assign MDBread = rd_sel ? ((BW & MAB[0]) ? 16'h0000 : {8'h00, iv_q}) : 16'hzzzz;

   // Vector, clear-target and request registers plus FSM state
   always_ff @(posedge MCLK or negedge reset_n) begin
      if (!reset_n) begin
         iv_q     <= TAIV_NONE;
         clrv_q   <= '0;
         tgt_q    <= '0;
         irq0_q   <= 1'b0;
         irq1_q   <= 1'b0;
         intack_q <= 1'b0;
         state_q  <= ST_IDLE;
      end else begin
         iv_q     <= iv_d;
         clrv_q   <= clrv_d;
         tgt_q    <= tgt_d;
         irq0_q   <= CCIFG[0] & CCIE[0];
         irq1_q   <= (|pend[NCCR-1:1]) | pend_t;
         intack_q <= INTACK0;
         state_q  <= state_d;
      end
   end

   // Access FSM: latch the vector seen at the access, fire one clear, wait for the access to end
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      clr_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (acc) begin
               state_d = ST_CLR;
               tgt_d   = clrv_q;
            end
         end
         ST_CLR: begin
            clr_fire = 1'b1;
            state_d  = acc ? ST_HOLD : ST_IDLE;
         end
         ST_HOLD: begin
            if (!acc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign IRQ0     = irq0_q;
   assign IRQ1     = irq1_q;
   assign CCIFGclr = (clr_fire ? tgt_q[NCCR-1:0] : '0) | {{(NCCR-1){1'b0}}, intack_q};
   assign TAIFGclr = clr_fire & tgt_q[NCCR];

endmodule

// File: tb/tb_timera_iv_ctrl.sv
// tb/tb_timera_iv_ctrl.sv - directed self-checking bench for timera_iv_ctrl
module tb_timera_iv_ctrl;
   import timera_iv_ctrl_pkg::*;

   logic        MCLK = 1'b0;
   logic        reset_n;
   logic [15:0] MAB, MDBwrite;
   logic        MR, MW, BW, TAIFG, TAIE, INTACK0;
   logic [2:0]  CCIFG, CCIE;
   wire  [15:0] MDBread;
   logic        IRQ0, IRQ1, TAIFGclr;
   logic [2:0]  CCIFGclr;

   int checks = 0;
   int errors = 0;

   timera_iv_ctrl #(.TAnIV(TA0IV), .NCCR(3)) dut (
      .MCLK(MCLK), .reset_n(reset_n), .MAB(MAB), .MDBwrite(MDBwrite),
      .MR(MR), .MW(MW), .BW(BW), .TAIFG(TAIFG), .TAIE(TAIE),
      .CCIFG(CCIFG), .CCIE(CCIE), .INTACK0(INTACK0), .MDBread(MDBread),
      .IRQ0(IRQ0), .IRQ1(IRQ1), .CCIFGclr(CCIFGclr), .TAIFGclr(TAIFGclr)
   );

   always #5 MCLK = ~MCLK;

   task automatic step();
      @(posedge MCLK);
      #1;
   endtask

   // Drives a read for one cycle, returns sampled data; returns 1 ns after the access edge
   task automatic do_read(input logic [15:0] addr, input logic bw, output logic [15:0] data);
      MAB = addr; MR = 1'b1; BW = bw;
      #1 data = MDBread;
      step();
      MR = 1'b0; BW = 1'b0;
   endtask

   task automatic clear_flags();
      CCIFG = 3'b000; CCIE = 3'b000; TAIFG = 1'b0; TAIE = 1'b0;
      step(); step();
   endtask

   task automatic test_reset();
      logic [15:0] d;
      reset_n = 1'b0;
      MAB = 16'h0; MDBwrite = 16'h0; MR = 0; MW = 0; BW = 0;
      TAIFG = 0; TAIE = 0; CCIFG = 0; CCIE = 0; INTACK0 = 0;
      step(); step();
      reset_n = 1'b1;
      step();
      checks++; if ({IRQ0, IRQ1} !== 2'b00) begin errors++; $display("FAIL reset_irq got %b exp 00", {IRQ0, IRQ1}); end
      checks++; if ({CCIFGclr, TAIFGclr} !== 4'b0000) begin errors++; $display("FAIL reset_clr got %b exp 0000", {CCIFGclr, TAIFGclr}); end
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_iv got %h exp 0000", d); end
      checks++; if ({CCIFGclr, TAIFGclr} !== 4'b0000) begin errors++; $display("FAIL reset_nopulse got %b exp 0000", {CCIFGclr, TAIFGclr}); end
      step();
   endtask

   task automatic test_priority();
      logic [15:0] d;
      CCIFG = 3'b110; CCIE = 3'b110; TAIFG = 1; TAIE = 1;
      step();
      checks++; if ({IRQ0, IRQ1} !== 2'b01) begin errors++; $display("FAIL prio_irq got %b exp 01", {IRQ0, IRQ1}); end
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL prio_iv1 got %h exp 0002", d); end
      checks++; if ({CCIFGclr, TAIFGclr} !== 4'b0100) begin errors++; $display("FAIL prio_clr1 got %b exp 0100", {CCIFGclr, TAIFGclr}); end
      CCIFG[1] = 1'b0;
      step();
      checks++; if (CCIFGclr !== 3'b000) begin errors++; $display("FAIL prio_oneshot got %b exp 000", CCIFGclr); end
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0004) begin errors++; $display("FAIL prio_iv2 got %h exp 0004", d); end
      checks++; if ({CCIFGclr, TAIFGclr} !== 4'b1000) begin errors++; $display("FAIL prio_clr2 got %b exp 1000", {CCIFGclr, TAIFGclr}); end
      CCIFG[2] = 1'b0;
      step();
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h000E) begin errors++; $display("FAIL prio_iv3 got %h exp 000e", d); end
      checks++; if ({CCIFGclr, TAIFGclr} !== 4'b0001) begin errors++; $display("FAIL prio_clr3 got %b exp 0001", {CCIFGclr, TAIFGclr}); end
      TAIFG = 1'b0;
      step();
      checks++; if (IRQ1 !== 1'b0) begin errors++; $display("FAIL prio_irq1_off got %b exp 0", IRQ1); end
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL prio_iv4 got %h exp 0000", d); end
      step();
      clear_flags();
   endtask

   task automatic test_byte_read();
      logic [15:0] d;
      CCIFG = 3'b100; CCIE = 3'b100;
      step(); step();
      do_read(TA0IV, 1'b1, d);
      checks++; if (d !== 16'h0004) begin errors++; $display("FAIL byte_lo got %h exp 0004", d); end
      step();
      do_read(TA0IV + 16'h1, 1'b1, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL byte_hi got %h exp 0000", d); end
      checks++; if (CCIFGclr !== 3'b100) begin errors++; $display("FAIL byte_hi_clr got %b exp 100", CCIFGclr); end
      step();
      clear_flags();
   endtask

   task automatic test_hold();
      int pulses;
      CCIFG = 3'b100; CCIE = 3'b100;
      step(); step();
      pulses = 0;
      MAB = TA0IV; MR = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 3) MR = 1'b0;
         pulses += int'(CCIFGclr[2]);
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
      clear_flags();
   endtask

   task automatic test_back_to_back();
      int pulses;
      CCIFG = 3'b100; CCIE = 3'b100;
      step(); step();
      pulses = 0;
      MAB = TA0IV; MR = 1'b1;
      step(); MR = 1'b0; pulses += int'(CCIFGclr[2]);
      step(); MR = 1'b1; pulses += int'(CCIFGclr[2]);
      step(); MR = 1'b0; pulses += int'(CCIFGclr[2]);
      step(); pulses += int'(CCIFGclr[2]);
      step(); pulses += int'(CCIFGclr[2]);
      checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
      clear_flags();
   endtask

   task automatic test_intack();
      logic [15:0] d;
      CCIFG = 3'b001; CCIE = 3'b001;
      step();
      checks++; if ({IRQ0, IRQ1} !== 2'b10) begin errors++; $display("FAIL ack_irq got %b exp 10", {IRQ0, IRQ1}); end
      INTACK0 = 1'b1;
      step();
      INTACK0 = 1'b0;
      checks++; if (CCIFGclr !== 3'b001) begin errors++; $display("FAIL ack_clr got %b exp 001", CCIFGclr); end
      step();
      checks++; if (CCIFGclr !== 3'b000) begin errors++; $display("FAIL ack_oneshot got %b exp 000", CCIFGclr); end
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ack_iv got %h exp 0000", d); end
      step();
      CCIFG = 3'b011; CCIE = 3'b011;
      step(); step();
      INTACK0 = 1'b1;
      do_read(TA0IV, 1'b0, d);
      INTACK0 = 1'b0;
      checks++; if (CCIFGclr !== 3'b011) begin errors++; $display("FAIL ack_both got %b exp 011", CCIFGclr); end
      step();
      clear_flags();
   endtask

   task automatic test_simultaneous();
      logic [15:0] d;
      TAIFG = 1; TAIE = 1;
      step(); step();
      CCIFG = 3'b010; CCIE = 3'b010;
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h000E) begin errors++; $display("FAIL sim_iv got %h exp 000e", d); end
      checks++; if ({CCIFGclr, TAIFGclr} !== 4'b0001) begin errors++; $display("FAIL sim_clr got %b exp 0001", {CCIFGclr, TAIFGclr}); end
      TAIFG = 1'b0;
      step();
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL sim_next got %h exp 0002", d); end
      step();
      clear_flags();
   endtask

   task automatic test_write();
      logic exp_clr;
`ifdef TIMERA_IV_WRITECLR_EN
      exp_clr = 1'b1;
`else
      exp_clr = 1'b0;
`endif
      TAIFG = 1; TAIE = 1;
      step(); step();
      MAB = TA0IV; MW = 1'b1; MDBwrite = 16'h1234;
      step();
      MW = 1'b0;
      checks++; if (TAIFGclr !== exp_clr) begin errors++; $display("FAIL write_clr got %b exp %b", TAIFGclr, exp_clr); end
      step();
      clear_flags();
   endtask

   task automatic test_reset_abort();
      logic [15:0] d;
      int pulses;
      TAIFG = 1; TAIE = 1;
      step(); step();
      MAB = TA0IV; MR = 1'b1;
      @(posedge MCLK);
      #1 reset_n = 1'b0; MR = 1'b0;
      #1;
      checks++; if ({IRQ0, IRQ1, CCIFGclr, TAIFGclr} !== 6'b0) begin errors++; $display("FAIL abort_out got %b exp 000000", {IRQ0, IRQ1, CCIFGclr, TAIFGclr}); end
      TAIE = 1'b0;
      step(); step();
      reset_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         pulses += int'(TAIFGclr) + int'(|CCIFGclr);
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL abort_pulses got %0d exp 0", pulses); end
      CCIFG = 3'b111; CCIE = 3'b000; TAIFG = 1; TAIE = 0;
      step(); step();
      checks++; if ({IRQ0, IRQ1} !== 2'b00) begin errors++; $display("FAIL masked_irq got %b exp 00", {IRQ0, IRQ1}); end
      do_read(TA0IV, 1'b0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL masked_iv got %h exp 0000", d); end
      step();
      clear_flags();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_byte_read();
      test_hold();
      test_back_to_back();
      test_intack();
      test_simultaneous();
      test_write();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
